// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and constants for the record-FIFO write arbiter: FSM states, source kinds,
// record width and default marker records.
package fifo_write_arbiter_pkg;

  localparam int unsigned REC_W = 48;
  localparam int unsigned STAT_W = 16;

  localparam logic [REC_W-1:0] LINE_MARKER_DEF  = 48'hFFFF_0000_0001;
  localparam logic [REC_W-1:0] FRAME_MARKER_DEF = 48'hFFFF_0000_0002;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_ACK
  } arb_state_t;

  typedef enum logic [1:0] {
    SRC_DATA,
    SRC_LINE,
    SRC_FRAME
  } src_kind_t;

  // Saturating increment for the statistics counters.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first requesting index at or after ptr, wrapping at N_REQ.
module rr_pick #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  int unsigned cand;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!valid && req[IDX_W'(cand)]) begin
        valid = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Shares the record-FIFO write port between N_REQ producers and injects line/frame markers.
// Optional statistics counters are built when ARB_STATS_EN is defined.
module fifo_write_arbiter
  import fifo_write_arbiter_pkg::*;
#(
  parameter int unsigned       N_REQ        = 3,
  parameter int unsigned       DATA_W       = REC_W,
  parameter logic [DATA_W-1:0] LINE_MARKER  = DATA_W'(LINE_MARKER_DEF),
  parameter logic [DATA_W-1:0] FRAME_MARKER = DATA_W'(FRAME_MARKER_DEF)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       soft_reset,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  output logic [N_REQ-1:0]           req_done,
  input  logic                       new_line,
  input  logic                       new_frame,
  output logic                       line_done,
  output logic                       frame_done,
  input  logic                       fifo_full,
  output logic                       fifo_wr_en,
  output logic [DATA_W-1:0]          fifo_din,
`ifdef ARB_STATS_EN
  output logic [STAT_W-1:0]          stat_writes,
  output logic [STAT_W-1:0]          stat_stalls,
`endif
  output logic [$clog2(N_REQ)-1:0]   grant_id
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  arb_state_t       state;
  src_kind_t        sel_kind;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] rr_ptr;
  logic             line_pend;
  logic             frame_pend;
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic             clr;
  logic [DATA_W-1:0] rec [N_REQ];

  assign clr = rst | soft_reset;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign rec[g] = req_data[g*DATA_W +: DATA_W];
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Arbitration FSM; outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= ST_IDLE;
      sel_kind   <= SRC_DATA;
      sel_idx    <= '0;
      rr_ptr     <= '0;
      line_pend  <= 1'b0;
      frame_pend <= 1'b0;
      req_done   <= '0;
      line_done  <= 1'b0;
      frame_done <= 1'b0;
      fifo_wr_en <= 1'b0;
      fifo_din   <= '0;
      grant_id   <= '0;
    end else begin
      req_done   <= '0;
      line_done  <= 1'b0;
      frame_done <= 1'b0;
      fifo_wr_en <= 1'b0;
      line_pend  <= line_pend | new_line;
      frame_pend <= frame_pend | new_frame;

      case (state)
        ST_IDLE: begin
          if (!fifo_full) begin
            if (line_pend) begin
              sel_kind   <= SRC_LINE;
              fifo_din   <= LINE_MARKER;
              fifo_wr_en <= 1'b1;
              state      <= ST_WRITE;
            end else if (frame_pend) begin
              sel_kind   <= SRC_FRAME;
              fifo_din   <= FRAME_MARKER;
              fifo_wr_en <= 1'b1;
              state      <= ST_WRITE;
            end else if (pick_valid) begin
              sel_kind   <= SRC_DATA;
              sel_idx    <= pick_idx;
              fifo_din   <= rec[pick_idx];
              fifo_wr_en <= 1'b1;
              state      <= ST_WRITE;
            end
          end
        end

        ST_WRITE: begin
          state <= ST_ACK;
          case (sel_kind)
            SRC_LINE:  line_done  <= 1'b1;
            SRC_FRAME: frame_done <= 1'b1;
            default: begin
              req_done <= N_REQ'(1) << sel_idx;
              grant_id <= sel_idx;
              rr_ptr   <= (sel_idx == IDX_W'(N_REQ - 1)) ? '0 : sel_idx + IDX_W'(1);
            end
          endcase
        end

        ST_ACK: begin
          state <= ST_IDLE;
          // A new pulse in this cycle re-arms the flag (set wins over clear).
          if (sel_kind == SRC_LINE)  line_pend  <= new_line;
          if (sel_kind == SRC_FRAME) frame_pend <= new_frame;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (clr) begin
      stat_writes <= '0;
      stat_stalls <= '0;
    end else begin
      if (fifo_wr_en) stat_writes <= sat_inc(stat_writes);
      if (state == ST_IDLE && fifo_full && (line_pend || frame_pend || (|req_valid)))
        stat_stalls <= sat_inc(stat_stalls);
    end
  end
`endif

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares the single record-FIFO write port between N record producers: the TDC channel plus auxiliary and fake channels.
- Also injects line and frame marker records on request from the MEMS scan controller.
- Sits between the producers and the FIFO / serial-out path in the FIFO manager.
- Replaces ad-hoc per-source write muxing with round-robin arbitration, FIFO-full backpressure and a per-source done handshake.

Parameters:
- N_REQ, 3, number of record producers; must be at least 2.
- DATA_W, 48, record width in bits.
- LINE_MARKER, 48'hFFFF_0000_0001, record written for new_line.
- FRAME_MARKER, 48'hFFFF_0000_0002, record written for new_frame.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- soft_reset  in  1  synchronous clear; same effect as rst.
- req_valid  in  N_REQ  per-producer write request; level, held until that producer's req_done.
- req_data  in  N_REQ*DATA_W  packed records; producer i occupies bits [i*DATA_W +: DATA_W]; stable while req_valid[i]=1.
- req_done  out  N_REQ  one-cycle pulse: producer's record has been written.
- new_line  in  1  one-cycle pulse: request a line marker.
- new_frame  in  1  one-cycle pulse: request a frame marker.
- line_done  out  1  one-cycle pulse: line marker written.
- frame_done  out  1  one-cycle pulse: frame marker written.
- fifo_full  in  1  FIFO full flag.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_din  out  DATA_W  FIFO write data.
- grant_id  out  clog2(N_REQ)  index of the last granted producer (debug).

Behaviour:
- All outputs are registered.
- Reset values (rst or soft_reset): req_done=0, line_done=0, frame_done=0, fifo_wr_en=0, fifo_din=0, grant_id=0.
- Reset also clears the pending flags and sets the round-robin pointer rr_ptr=0.
- Reset mid-operation aborts immediately: no wr_en and no done pulse are emitted afterwards.
- Pending flags: line_pend is set by new_line, frame_pend by new_frame. A set in the same cycle as a clear wins.
- Repeated pulses while a flag is pending merge into one marker.
- FSM states: IDLE, WRITE, ACK.
- IDLE, fifo_full=1: stay in IDLE; nothing is written.
- IDLE, fifo_full=0, selection priority:
  - line_pend, then frame_pend, then producers in round-robin order starting at rr_ptr.
  - If something is selected: latch the source, load fifo_din, go to WRITE. No source selected: stay in IDLE.
- WRITE: fifo_wr_en=1 for exactly this one cycle; go to ACK.
  - A data grant sets rr_ptr = granted index + 1, wrapping from N_REQ-1 to 0, and sets grant_id.
- ACK: the selected done output is high for exactly this one cycle.
  - A marker grant clears its pending flag.
  - Return to IDLE.
  - A producer must drop req_valid on the edge ending its req_done cycle; req_valid is not sampled in ACK, so no double grant occurs.
- Latency and throughput: request sampled in IDLE at cycle 0 → fifo_wr_en in cycle 1 → done in cycle 2 → IDLE in cycle 3. Sustained rate is one record per 3 cycles.
- fifo_full is sampled only in IDLE. A full rising during WRITE does not cancel the write, because the FIFO asserts full one write early (almost-full semantics).
- Fairness: with all producers continuously requesting and no markers, each producer gets exactly one grant per N_REQ data writes.
- Markers preempt data only between records, never mid-handshake.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined: adds outputs stat_writes[15:0] and stat_stalls[15:0].
  - stat_writes counts fifo_wr_en cycles.
  - stat_stalls counts IDLE cycles with a pending source and fifo_full=1.
  - Both saturate at 16'hFFFF and are cleared by rst or soft_reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package holds the FSM state enum (IDLE/WRITE/ACK), LINE_MARKER and FRAME_MARKER defaults, and the record width constant shared with the FIFO manager and tdc_control.
- One sub-module is natural: rr_pick. It is a combinational round-robin priority picker: inputs req vector and rr_ptr; outputs a valid flag and the selected index.

Test Plan:
- Single producer: req_valid=3'b001 with data 48'h0000_1234_5678 → fifo_wr_en in cycle 1 with that data; req_done[0] in cycle 2; grant_id=0.
- All three valid continuously, each producer re-asserting after its done → grant order 0,1,2,0,1,2; 6 writes in 18 cycles.
- new_line and new_frame pulsed together while producer 1 is valid → write order LINE_MARKER, FRAME_MARKER, then producer 1's data; line_done and frame_done each pulse once.
- fifo_full=1 for 10 cycles with producer 2 valid → no fifo_wr_en; write occurs 1 cycle after full drops; stat_stalls=10 when ARB_STATS_EN is defined.
- new_line pulsed twice while fifo_full=1 → exactly one LINE_MARKER write after full drops.
- rst asserted in the WRITE cycle → next cycle all outputs 0 and no req_done; a request still valid is re-granted from IDLE with rr_ptr=0.
